spi_slave_sck_ctrl: RTL and testbench
=====================================

# spi_slave_sck_ctrl

Next-generation SPI slave clock/select front end: synchronises raw `sck` and `cs` pads into the `clk` domain, decodes all four CPOL/CPHA modes into single-cycle sample and shift strobes, counts bits, and frames configurable-length words (multiple words per `cs` assertion). It sits between the pads and the slave shift register / word FIFO, replacing bare edge detection with mode latching, a bit counter, word framing and abort detection.

## Interface
- `SPI_MAX_WIDTH_LOG`, 4, width of `spi_width` and `bit_index`; max word length 2^SPI_MAX_WIDTH_LOG bits
- `SYNC_STAGES`, 2, flops per pad synchroniser; legal ≥ 2
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `cpol` in 1: idle level of `sck`; latched at frame start
- `cpha` in 1: 0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start
- `spi_width` in SPI_MAX_WIDTH_LOG: word length minus 1; latched at frame start
- `sck` in 1: raw pad, asynchronous
- `cs` in 1: raw pad, active low, asynchronous
- `spi_start` out 1: one-cycle pulse, synced `cs` 1→0
- `spi_finish` out 1: one-cycle pulse, synced `cs` 0→1
- `frame_abort` out 1: pulse with `spi_finish` when the word was incomplete
- `busy` out 1: high while synced `cs` low
- `sample_strobe` out 1: one-cycle pulse, capture MOSI now
- `shift_strobe` out 1: one-cycle pulse, advance MISO now
- `bit_index` out SPI_MAX_WIDTH_LOG: index of bit to be sampled next, 0 = first bit
- `word_done` out 1: pulse coincident with the sample strobe of the last bit

## Operation
- Reset: every output 0; `sck` sync chain resets to 0, `cs` chain to 1 (deasserted), so no spurious `spi_start` on reset release. Latched mode registers reset to 0, bit counter to 0.
- Leading edge: rising edge of `sck_h` = synced `sck` XOR latched `cpol`; trailing edge: falling edge of `sck_h`.
- Mode latch: `cpol`, `cpha` and `spi_width` are captured on the `spi_start` cycle. Changes while `busy` have no effect until the next frame.
- `cpha`=0: leading → `sample_strobe`; trailing → `shift_strobe`.
- `cpha`=1: leading → `shift_strobe`, except the first leading edge of each word, which is suppressed (bit 0 is preloaded); trailing → `sample_strobe`.
- Bit counter increments on `sample_strobe`. At `bit_index == spi_width`, `word_done` pulses with that `sample_strobe` and the counter wraps to 0. The next word starts without `cs` toggling.
- `spi_start` clears the bit counter and re-arms the first-shift suppression.
- `spi_finish` with `bit_index != 0` also pulses `frame_abort`. The counter clears in the same cycle.
- While `cs` is high (synced), all `sck` edges are ignored, and no strobe is asserted.
- `spi_start` and an `sck` edge in the same cycle: start wins and that edge is dropped. The master must honour setup time.
- `spi_finish` and an `sck` edge in the same cycle: finish wins and the edge is dropped.
- Reset asserted mid-frame: immediate return to reset values. After release, a `cs` that is still low does not produce `spi_start`, and `busy` stays 0 until a full high→low `cs` cycle occurs.

## Timing
- A pad level first captured at `clk` edge k appears on the synchroniser output after edge k+SYNC_STAGES-1. The strobe is high for exactly the following cycle (registered compare against the previous synced value).
- All outputs are registered or derive combinationally only from registers, so there is no pad-to-output path.
- Requirement: each `sck` high or low phase lasts ≥ SYNC_STAGES+1 `clk` periods (f_clk ≥ 2·(SYNC_STAGES+1)·f_sck), and `cs` setup to the first edge is ≥ SYNC_STAGES+1 `clk` periods.
- `bit_index` updates the cycle after `sample_strobe`.

## Structure
- Shared package `spi_slave_pkg`:
  - mode encoding constants `SPI_MODE0`..`SPI_MODE3` ({cpol,cpha})
  - default `SPI_MAX_WIDTH_LOG`
  - default `SYNC_STAGES`
- Sub-module `spi_pad_sync`: parameters STAGES and RESET_VAL; N-flop synchroniser with async reset. Instantiated once for `sck` (RESET_VAL 0) and once for `cs` (RESET_VAL 1).
- Top holds the edge compare, mode latch, suppression flag, bit counter and framing logic.

## Test plan
- Mode 0, `spi_width`=7, one 8-bit word:
  - 8 `sample_strobe` (one per rising `sck`) and 8 `shift_strobe`
  - `word_done` on the 8th sample
  - `bit_index` back to 0
  - `spi_finish` with `frame_abort`=0
- Mode 3, `spi_width`=7, two back-to-back words in one `cs` low:
  - first leading edge of each word produces no `shift_strobe` (7 shifts per word)
  - samples on rising pad `sck`
  - two `word_done` pulses
- Mode 1, `spi_width`=15: `cs` released after 5 samples → `spi_finish` and `frame_abort` in the same cycle, and `bit_index` = 0 the next cycle.
- Mode 2, `cpol` toggled mid-frame: decoded strobes are unchanged. The next frame uses the new value.
- Mode 0, `sck` toggles while `cs` high: zero strobes. `cs` falling plus `sck` rising in the same `clk` cycle: `spi_start` only, no `sample_strobe`.
- `rst_n` pulsed low during word with `cs` held low:
  - all outputs 0 during reset
  - after release, no `spi_start` and `busy`=0 until `cs` goes high then low again

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave front end: mode encoding and default sizing.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_t;

  localparam int DEF_SPI_MAX_WIDTH_LOG = 4;
  localparam int DEF_SYNC_STAGES       = 2;

endpackage

// File: rtl/spi_slave_sck_ctrl_if.sv
// Pad, configuration and strobe bundle between the SPI pads/config and the clock front end.
interface spi_slave_sck_ctrl_if #(
  parameter int SPI_MAX_WIDTH_LOG = spi_slave_pkg::DEF_SPI_MAX_WIDTH_LOG
);
  logic                         cpol;
  logic                         cpha;
  logic [SPI_MAX_WIDTH_LOG-1:0] spi_width;
  logic                         sck;
  logic                         cs;
  logic                         spi_start;
  logic                         spi_finish;
  logic                         frame_abort;
  logic                         busy;
  logic                         sample_strobe;
  logic                         shift_strobe;
  logic [SPI_MAX_WIDTH_LOG-1:0] bit_index;
  logic                         word_done;

  modport slave (
    input  cpol, cpha, spi_width, sck, cs,
    output spi_start, spi_finish, frame_abort, busy,
           sample_strobe, shift_strobe, bit_index, word_done
  );

  modport master (
    output cpol, cpha, spi_width, sck, cs,
    input  spi_start, spi_finish, frame_abort, busy,
           sample_strobe, shift_strobe, bit_index, word_done
  );
endinterface

// File: rtl/spi_pad_sync.sv
// Multi-flop synchroniser for one asynchronous pad; reset value chosen per pad.
module spi_pad_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic synced
);
  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], pad};
    end
  end

  assign synced = sync_reg[STAGES-1];
endmodule

// File: rtl/spi_slave_sck_ctrl.sv
// SPI slave clock/select front end: pad sync, CPOL/CPHA strobe decode, bit counting and
// word framing with abort detection. All outputs come straight from registers.
module spi_slave_sck_ctrl
  import spi_slave_pkg::*;
#(
  parameter int SPI_MAX_WIDTH_LOG = DEF_SPI_MAX_WIDTH_LOG,
  parameter int SYNC_STAGES       = DEF_SYNC_STAGES
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_slave_sck_ctrl_if.slave bus
);
  logic sck_sync;
  logic cs_sync;

  spi_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .pad(bus.sck), .synced(sck_sync)
  );

  spi_pad_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .pad(bus.cs), .synced(cs_sync)
  );

  logic                         sck_prev_reg;
  logic                         cs_prev_reg;
  logic [SYNC_STAGES-1:0]       fill_reg;
  logic                         armed_reg;
  spi_mode_t                    mode_reg;
  logic [SPI_MAX_WIDTH_LOG-1:0] width_reg;
  logic [SPI_MAX_WIDTH_LOG-1:0] bit_cnt_reg;
  logic                         suppress_reg;
  logic                         start_reg;
  logic                         finish_reg;
  logic                         abort_reg;
  logic                         busy_reg;
  logic                         sample_reg;
  logic                         shift_reg;
  logic                         word_done_reg;

  logic start_det;
  logic finish_det;
  logic h_now;
  logic h_prev;
  logic lead;
  logic trail;
  logic sample_next;
  logic shift_next;
  logic last_bit;

  // Framing is only armed once the cs chain holds a genuine high sample, so a cs
  // held low across reset release cannot look like a falling edge.
  always_comb begin
    h_now       = sck_sync ^ mode_reg[1];
    h_prev      = sck_prev_reg ^ mode_reg[1];
    start_det   = armed_reg && cs_prev_reg && !cs_sync;
    finish_det  = busy_reg && !cs_prev_reg && cs_sync;
    lead        = busy_reg && !finish_det && h_now && !h_prev;
    trail       = busy_reg && !finish_det && !h_now && h_prev;
    sample_next = mode_reg[0] ? trail : lead;
    shift_next  = mode_reg[0] ? (lead && !suppress_reg) : trail;
    last_bit    = (bit_cnt_reg == width_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev_reg  <= 1'b0;
      cs_prev_reg   <= 1'b1;
      fill_reg      <= '0;
      armed_reg     <= 1'b0;
      mode_reg      <= SPI_MODE0;
      width_reg     <= '0;
      bit_cnt_reg   <= '0;
      suppress_reg  <= 1'b0;
      start_reg     <= 1'b0;
      finish_reg    <= 1'b0;
      abort_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      sample_reg    <= 1'b0;
      shift_reg     <= 1'b0;
      word_done_reg <= 1'b0;
    end else begin
      sck_prev_reg  <= sck_sync;
      cs_prev_reg   <= cs_sync;
      fill_reg      <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
      if (fill_reg[SYNC_STAGES-1] && cs_sync) begin
        armed_reg <= 1'b1;
      end

      start_reg     <= start_det;
      finish_reg    <= finish_det;
      abort_reg     <= finish_det && (bit_cnt_reg != '0);
      sample_reg    <= sample_next;
      shift_reg     <= shift_next;
      word_done_reg <= sample_next && last_bit;

      if (start_det) begin
        busy_reg  <= 1'b1;
        mode_reg  <= spi_mode_t'({bus.cpol, bus.cpha});
        width_reg <= bus.spi_width;
      end else if (finish_det) begin
        busy_reg <= 1'b0;
      end

      // Re-arm the preloaded-bit suppression at every word boundary.
      if (start_det || (sample_next && last_bit)) begin
        suppress_reg <= 1'b1;
      end else if (lead) begin
        suppress_reg <= 1'b0;
      end

      // The index advances one cycle after the strobe so it names the bit being sampled.
      if (start_det || finish_det) begin
        bit_cnt_reg <= '0;
      end else if (sample_reg) begin
        bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.spi_start     = start_reg;
  assign bus.spi_finish    = finish_reg;
  assign bus.frame_abort   = abort_reg;
  assign bus.busy          = busy_reg;
  assign bus.sample_strobe = sample_reg;
  assign bus.shift_strobe  = shift_reg;
  assign bus.bit_index     = bit_cnt_reg;
  assign bus.word_done     = word_done_reg;
endmodule

// File: tb/tb_spi_slave_sck_ctrl.sv
// Scoreboard bench for spi_slave_sck_ctrl: pad stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT emits strobes.
module tb_spi_slave_sck_ctrl;
  import spi_slave_pkg::*;

  localparam int W    = DEF_SPI_MAX_WIDTH_LOG;
  localparam int HALF = 6;
  localparam logic [3:0] K_START  = 4'd1;
  localparam logic [3:0] K_FINISH = 4'd2;
  localparam logic [3:0] K_SAMPLE = 4'd3;
  localparam logic [3:0] K_SHIFT  = 4'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_sck_ctrl_if #(.SPI_MAX_WIDTH_LOG(W)) bus();

  spi_slave_sck_ctrl #(.SPI_MAX_WIDTH_LOG(W), .SYNC_STAGES(DEF_SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  int   mcnt = 0;
  int   mwidth = 0;
  logic m_cpol = 1'b0;
  logic m_cpha = 1'b0;
  logic m_supp = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ev(logic [3:0] k, int idx, logic f);
    logic [3:0] i4;
    i4 = idx[3:0];
    return {k, i4, 7'd0, f};
  endfunction

  function automatic logic [31:0] outs();
    return {20'd0, bus.spi_start, bus.spi_finish, bus.frame_abort, bus.busy,
            bus.sample_strobe, bus.shift_strobe, bus.word_done, 1'b0, 4'(bus.bit_index)};
  endfunction

  task automatic pop_check(string tag, logic [15:0] obs);
    logic [15:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
    check(tag, {16'd0, obs}, {16'd0, exp});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.spi_start)     pop_check("start",  ev(K_START, int'(bus.bit_index), bus.busy));
      if (bus.spi_finish)    pop_check("finish", ev(K_FINISH, 0, bus.frame_abort));
      if (bus.sample_strobe) pop_check("sample", ev(K_SAMPLE, int'(bus.bit_index), bus.word_done));
      if (bus.shift_strobe)  pop_check("shift",  ev(K_SHIFT, int'(bus.bit_index), 1'b0));
      if (bus.word_done && !bus.sample_strobe) check("lone_word_done", 1, 0);
      if (bus.frame_abort && !bus.spi_finish)  check("lone_abort", 1, 0);
    end
  end

  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  // One pad edge; the model decides which strobe it must produce.
  task automatic do_edge();
    logic lead;
    logic done;
    bus.sck = ~bus.sck;
    lead = (bus.sck != m_cpol);
    done = (mcnt == mwidth);
    if (!m_cpha) begin
      if (lead) begin
        exp_q.push_back(ev(K_SAMPLE, mcnt, done));
        mcnt = done ? 0 : mcnt + 1;
      end else begin
        exp_q.push_back(ev(K_SHIFT, mcnt, 1'b0));
      end
    end else begin
      if (lead) begin
        if (m_supp) m_supp = 1'b0;
        else exp_q.push_back(ev(K_SHIFT, mcnt, 1'b0));
      end else begin
        exp_q.push_back(ev(K_SAMPLE, mcnt, done));
        mcnt = done ? 0 : mcnt + 1;
        if (done) m_supp = 1'b1;
      end
    end
    wait_clk(HALF);
  endtask

  task automatic frame_start(logic c_pol, logic c_pha, int width);
    bus.cpol = c_pol;
    bus.cpha = c_pha;
    bus.spi_width = W'(width);
    bus.sck = c_pol;
    wait_clk(HALF);
    bus.cs = 1'b0;
    exp_q.push_back(ev(K_START, 0, 1'b1));
    m_cpol = c_pol;
    m_cpha = c_pha;
    mwidth = width;
    mcnt = 0;
    m_supp = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic frame_end(string tag);
    bus.cs = 1'b1;
    exp_q.push_back(ev(K_FINISH, 0, mcnt != 0));
    wait_clk(HALF);
    check({tag, "_idx"}, 32'(bus.bit_index), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b1;
    bus.sck = 1'b0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.spi_width = '0;
    wait_clk(3);
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    wait_clk(10);
    check("idle_outs", outs(), 0);

    frame_start(1'b0, 1'b0, 7);
    repeat (16) do_edge();
    frame_end("mode0");

    frame_start(1'b1, 1'b1, 7);
    repeat (32) do_edge();
    frame_end("mode3");

    frame_start(1'b0, 1'b1, 15);
    repeat (10) do_edge();
    frame_end("mode1_abort");

    // cpol flipped mid-frame must not change decoding until the next frame
    frame_start(1'b1, 1'b0, 7);
    repeat (6) do_edge();
    bus.cpol = 1'b0;
    repeat (10) do_edge();
    frame_end("mode2");
    frame_start(bus.cpol, 1'b0, 7);
    repeat (16) do_edge();
    frame_end("mode2_next");

    // sck activity with cs high: the monitor rejects any strobe
    repeat (6) begin
      bus.sck = ~bus.sck;
      wait_clk(HALF);
    end
    check("cs_high_quiet", exp_q.size(), 0);

    // cs fall and sck rise together: start only, edge dropped
    bus.spi_width = W'(7);
    bus.cs = 1'b0;
    bus.sck = 1'b1;
    exp_q.push_back(ev(K_START, 0, 1'b1));
    m_cpol = 1'b0;
    m_cpha = 1'b0;
    mwidth = 7;
    mcnt = 0;
    m_supp = 1'b1;
    wait_clk(HALF);
    do_edge();
    frame_end("start_edge");

    // reset mid-word with cs held low
    frame_start(1'b0, 1'b0, 7);
    repeat (5) do_edge();
    check("pre_rst_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async", outs(), 0);
    wait_clk(3);
    check("rst_hold", outs(), 0);
    bus.sck = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(10);
    bus.sck = 1'b1;
    wait_clk(HALF);
    bus.sck = 1'b0;
    wait_clk(HALF);
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_idx", 32'(bus.bit_index), 0);
    check("post_rst_drain", exp_q.size(), 0);
    bus.cs = 1'b1;
    wait_clk(HALF);
    frame_start(1'b0, 1'b0, 7);
    repeat (16) do_edge();
    frame_end("post_rst");

    check("final_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
